// File: rtl/fp_dot_accumulator.sv
// FP32 dot-product accumulator: sums a product stream onto a bias and emits one result per in_last.
// Optional macro FP_DOT_ACC_RELU_EN fuses a ReLU onto out_data.
//
// state | meaning
// IDLE  | waiting for first beat of a result; bias_in seeds the sum
// ACCUM | adding further beats into acc
// DONE  | result presented on out_data until out_ready
module fp_dot_accumulator #(
  parameter int MAX_TERMS = 256,
  parameter int CNT_W     = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      bias_in,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] term_count,
  output logic             overflow_err
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t      state;
  logic [31:0] acc;
  logic [31:0] add_a;
  logic [31:0] sum_next;
  logic        beat;

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic              sx, sy;
    logic [7:0]        ex, ey, d;
    logic [27:0]       x, y, y_sh, sum;
    logic              sticky, round_up, found;
    logic [4:0]        lz;
    logic signed [9:0] e;
    logic [23:0]       frac_r;
    logic [31:0]       r;
    r = 32'h0; sx = 1'b0; sy = 1'b0; ex = 8'h0; ey = 8'h0; d = 8'h0;
    x = 28'h0; y = 28'h0; y_sh = 28'h0; sum = 28'h0;
    sticky = 1'b0; round_up = 1'b0; found = 1'b0; lz = 5'd0; e = 10'sd0; frac_r = 24'h0;
    if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) || (b[30:23] == 8'hFF && b[22:0] != 23'h0))
      r = QNAN;
    else if (a[30:23] == 8'hFF && b[30:23] == 8'hFF)
      r = (a[31] != b[31]) ? QNAN : a;
    else if (a[30:23] == 8'hFF)
      r = a;
    else if (b[30:23] == 8'hFF)
      r = b;
    else if (a[30:23] == 8'h00 && b[30:23] == 8'h00)
      r = {a[31] & b[31], 31'h0};
    else if (a[30:23] == 8'h00)
      r = b;
    else if (b[30:23] == 8'h00)
      r = a;
    else begin
      if (a[30:0] >= b[30:0]) begin
        sx = a[31]; ex = a[30:23]; x = {2'b01, a[22:0], 3'b000};
        sy = b[31]; ey = b[30:23]; y = {2'b01, b[22:0], 3'b000};
      end else begin
        sx = b[31]; ex = b[30:23]; x = {2'b01, b[22:0], 3'b000};
        sy = a[31]; ey = a[30:23]; y = {2'b01, a[22:0], 3'b000};
      end
      d      = ex - ey;
      // shifts of 28 or more leave y_sh=0 and the mask covers all of y, so no special case
      y_sh   = y >> d;
      sticky = |(y & ((28'd1 << d) - 28'd1));
      y_sh[0] = y_sh[0] | sticky;
      sum    = (sx == sy) ? (x + y_sh) : (x - y_sh);
      e      = $signed({2'b00, ex});
      if (sum == 28'h0) begin
        r = 32'h0;
      end else begin
        if (sum[27]) begin
          sum = {1'b0, sum[27:2], sum[1] | sum[0]};
          e   = e + 10'sd1;
        end else begin
          for (int i = 26; i >= 0; i--) begin
            if (!found) begin
              if (sum[i]) found = 1'b1;
              else        lz = lz + 5'd1;
            end
          end
          sum = sum << lz;
          e   = e - $signed({5'b00000, lz});
        end
        round_up = sum[2] & (sum[1] | sum[0] | sum[3]);
        frac_r   = {1'b0, sum[25:3]} + {23'h0, round_up};
        if (frac_r[23]) e = e + 10'sd1;
        if (e <= 10'sd0)       r = 32'h0;
        else if (e >= 10'sd255) r = {sx, 8'hFF, 23'h0};
        else                   r = {sx, e[7:0], frac_r[22:0]};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] out_map(input logic [31:0] v);
`ifdef FP_DOT_ACC_RELU_EN
    if (v[31] && !(v[30:23] == 8'hFF && v[22:0] != 23'h0)) return 32'h0;
    return v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    add_a    = (state == S_IDLE) ? bias_in : acc;
    sum_next = fp_add(add_a, in_data);
    beat     = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      acc          <= 32'h0;
      out_data     <= 32'h0;
      out_valid    <= 1'b0;
      in_ready     <= 1'b1;
      term_count   <= '0;
      overflow_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ACCUM: begin
          if (beat) begin
            acc <= sum_next;
            if (state == S_IDLE) begin
              term_count   <= CNT_W'(1);
              overflow_err <= 1'b0;
              state        <= S_ACCUM;
            end else if (term_count == CNT_W'(MAX_TERMS)) begin
              overflow_err <= 1'b1;
            end else begin
              term_count <= term_count + CNT_W'(1);
            end
            if (in_last) begin
              state     <= S_DONE;
              out_data  <= out_map(sum_next);
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_dot_accumulator.sv
// Bench for fp_dot_accumulator (MAX_TERMS=4): directed cases plus random streams checked
// against a double-precision reference; honours FP_DOT_ACC_RELU_EN when defined.
module tb_fp_dot_accumulator;

  localparam int MAX_TERMS = 4;
  localparam int CNT_W     = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      bias_in, in_data;
  logic             in_valid, in_last, in_ready;
  logic [31:0]      out_data;
  logic             out_valid, out_ready;
  logic [CNT_W-1:0] term_count;
  logic             overflow_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] beats [16];

  fp_dot_accumulator #(.MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bias_in(bias_in), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .term_count(term_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // float bits -> double bits, with denormal inputs flushed to signed zero
  function automatic logic [63:0] f2d(input logic [31:0] f);
    if (f[30:23] == 8'h00) return {f[31], 63'h0};
    if (f[30:23] == 8'hFF) return {f[31], 11'h7FF, f[22:0] != 23'h0, 51'h0};
    return {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0};
  endfunction

  // double -> float, round to nearest even; tiny results flush to +0
  function automatic logic [31:0] d2f(input logic [63:0] dv);
    logic [24:0] m;
    logic [28:0] rem;
    int fe;
    if (dv[62:52] == 11'h7FF) return (dv[51:0] != 52'h0) ? 32'h7FC0_0000 : {dv[63], 8'hFF, 23'h0};
    if (dv[62:52] == 11'h000) return {dv[63], 31'h0};
    m   = {2'b01, dv[51:29]};
    rem = dv[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 25'd1;
    fe = int'(dv[62:52]) - 896;
    if (m[24]) begin fe++; m = m >> 1; end
    if (fe >= 255) return {dv[63], 8'hFF, 23'h0};
    if (fe <= 0) return 32'h0;
    return {dv[63], 8'(fe), m[22:0]};
  endfunction

  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    real ra, rb;
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 32'h7FC0_0000;
    ra = $bitstoreal(f2d(a));
    rb = $bitstoreal(f2d(b));
    return d2f($realtobits(ra + rb));
  endfunction

  function automatic logic [31:0] relu_model(input logic [31:0] v);
`ifdef FP_DOT_ACC_RELU_EN
    if (v[31] && !(v[30:23] == 8'hFF && v[22:0] != 0)) return 32'h0;
`endif
    return v;
  endfunction

  function automatic logic [31:0] rand_fp();
    int k;
    logic s;
    k = $urandom_range(0, 99);
    s = 1'($urandom);
    if (k < 78) return {s, 8'($urandom_range(112, 140)), 23'($urandom)};
    if (k < 84) return {s, 8'h00, (k < 81) ? 23'h0 : 23'($urandom)};
    if (k < 90) return {s, 8'($urandom_range(252, 254)), 23'($urandom)};
    if (k < 94) return {s, 8'h67, 23'($urandom_range(0, 3))};
    if (k < 97) return {s, 8'hFF, 23'h0};
    return {s, 8'hFF, 23'($urandom_range(1, 8388607))};
  endfunction

  task automatic run_result(input string tag, input logic [31:0] bias, input int n,
                            input int hold, input bit junk);
    logic [31:0] exp_acc;
    int exp_cnt;
    exp_acc = bias;
    for (int i = 0; i < n; i++) exp_acc = model_add(exp_acc, beats[i]);
    exp_acc = relu_model(exp_acc);
    exp_cnt = (n > MAX_TERMS) ? MAX_TERMS : n;
    for (int i = 0; i < n; i++) begin
      bias_in  = (i == 0) ? bias : $urandom;
      in_data  = beats[i];
      in_valid = 1'b1;
      in_last  = (i == n - 1);
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, " early_valid"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " out_data"}, out_data, exp_acc);
    chk({tag, " term_count"}, 32'(term_count), 32'(exp_cnt));
    chk({tag, " overflow_err"}, 32'(overflow_err), 32'(n > MAX_TERMS));
    chk({tag, " busy"}, 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      if (junk) begin in_valid = 1'b1; in_data = $urandom; end
      @(posedge clk); #1;
      chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold_data"}, out_data, exp_acc);
      chk({tag, " hold_busy"}, 32'(in_ready), 32'd0);
      chk({tag, " hold_count"}, 32'(term_count), 32'(exp_cnt));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " drained"}, 32'(out_valid), 32'd0);
    chk({tag, " ready_again"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] bias, running;
    int n;
    reset = 1'b1; bias_in = 32'h0; in_data = 32'h0;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_data", out_data, 32'h0);
    chk("rst term_count", 32'(term_count), 32'd0);
    chk("rst overflow", 32'(overflow_err), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    beats[0] = 32'h3F80_0000; beats[1] = 32'h4000_0000; beats[2] = 32'h4040_0000;
    run_result("sum3", 32'h0, 3, 0, 1'b0);
    beats[0] = 32'hBF80_0000;
    run_result("cancel", 32'h3F80_0000, 1, 0, 1'b0);
    beats[0] = 32'h3380_0000;
    run_result("tie_even", 32'h3F80_0000, 1, 0, 1'b0);
    beats[0] = 32'h3380_0001;
    run_result("round_up", 32'h3F80_0000, 1, 0, 1'b0);
    beats[0] = 32'hFF80_0000;
    run_result("inf_minus_inf", 32'h7F80_0000, 1, 0, 1'b0);
    beats[0] = 32'h7F7F_FFFF;
    run_result("ovf_inf", 32'h7F7F_FFFF, 1, 0, 1'b0);
    beats[0] = 32'h3F80_0000;
    run_result("snan", 32'h7FA0_0000, 1, 0, 1'b0);
    beats[0] = 32'h8000_0000;
    run_result("neg_zero", 32'h8000_0000, 1, 0, 1'b0);
    beats[0] = 32'h3F80_0000;
    run_result("denorm_in", 32'h0000_0001, 1, 0, 1'b0);
    beats[0] = 32'h3F80_0000; beats[1] = 32'h4000_0000; beats[2] = 32'h4040_0000;
    run_result("backpressure", 32'h0, 3, 5, 1'b1);
    for (int i = 0; i < 5; i++) beats[i] = 32'h3F80_0000;
    run_result("max_terms", 32'h0, 5, 1, 1'b0);

    // reset in the middle of a result discards it
    bias_in = 32'h3F80_0000; in_data = 32'h4000_0000; in_valid = 1'b1; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_data", out_data, 32'h0);
    chk("midrst term_count", 32'(term_count), 32'd0);
    chk("midrst overflow", 32'(overflow_err), 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst no_result", 32'(out_valid), 32'd0);

    beats[0] = 32'hC000_0000;
    run_result("relu", 32'h0, 1, 0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      n       = $urandom_range(1, 6);
      bias    = rand_fp();
      running = bias;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) == 0) beats[i] = running ^ 32'h8000_0000;
        else                           beats[i] = rand_fp();
        running = model_add(running, beats[i]);
      end
      run_result("rand", bias, n, $urandom_range(0, 2), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
